conv_coeff_ctrl: RTL
====================

CONV_COEFF_CTRL -- requirements
Module: conv_coeff_ctrl

Interface
REQ-001 Parameter COEFF_W, default 9: coefficient width in bits, two's complement.
REQ-002 Parameter N_COEFF, default 9: number of kernel taps (3x3 kernel).
REQ-003 clk  input  1  sole clock; all logic is rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 vs_i  input  1  vertical sync; high marks the coefficient-load window of the convolution datapath.
REQ-006 wr_valid_i  input  1  host write request into the shadow bank.
REQ-007 wr_ready_o  output  1  shadow bank accepts a write.
REQ-008 wr_addr_i  input  4  tap index, valid range 0..N_COEFF-1.
REQ-009 wr_data_i  input  COEFF_W  coefficient value.
REQ-010 commit_i  input  1  one-cycle strobe requesting shadow-to-active bank swap.
REQ-011 pending_o  output  1  commit accepted but swap not yet done.
REQ-012 addr_err_o  output  1  sticky flag: a write to an out-of-range address was accepted.
REQ-013 coeff_o  output  COEFF_W  coefficient stream to the convolution coeff_i input.
REQ-014 stream_o  output  1  high during the N_COEFF cycles in which coeff_o carries taps 0..N_COEFF-1.

Function
REQ-015 Two register banks of N_COEFF x COEFF_W each: shadow (host-writable) and active (streamed).
REQ-016 A write completes in a cycle with wr_valid_i=1 and wr_ready_o=1; shadow[wr_addr_i] <= wr_data_i when wr_addr_i < N_COEFF.
REQ-017 A completed write with wr_addr_i >= N_COEFF leaves both banks unchanged and sets addr_err_o to 1 until reset.
REQ-018 wr_ready_o = ~pending_o; the shadow bank is locked while a swap is pending.
REQ-019 commit_i=1 while pending_o=0 sets pending_o on the next edge; commit_i while pending_o=1 is ignored.
REQ-020 commit_i and a completed write in the same cycle: the write is applied first; the commit then covers it.
REQ-021 Swap: in any cycle with pending_o=1 and state IDLE, active <= shadow (all taps at once) and pending_o <= 0.
REQ-022 FSM states IDLE, STREAM, HOLD; an index counter idx counts 0..N_COEFF-1.
REQ-023 IDLE (vs_i=0): idx=0; coeff_o <= active-after-any-same-cycle-swap[0]; stream_o=0; vs_i=1 -> STREAM.
REQ-024 STREAM: coeff_o equals active[idx] in the cycle idx is current; coeff_o <= active[idx+1] and idx increments each cycle; stream_o=1.
REQ-025 In STREAM, idx=N_COEFF-1 -> HOLD with coeff_o <= 0; vs_i=0 at any point -> IDLE (abort, idx cleared).
REQ-026 HOLD: coeff_o=0, stream_o=0; vs_i=0 -> IDLE.
REQ-027 Timing: in the first cycle vs_i is sampled high, coeff_o = active[0]; tap k appears k cycles later, matching the datapath's address counter that clears while vs_i is low and increments while vs_i is high.
REQ-028 Latency commit_i to swap: 1 cycle if state IDLE, else the first IDLE cycle after vs_i falls.
REQ-029 vs_i must be low at least 2 cycles between frames so the post-swap tap 0 reaches coeff_o; shorter gaps stream the previous active bank for that frame.
REQ-030 The active bank never changes while state is STREAM or HOLD.

Reset
REQ-031 With rst_n=0 at a rising edge: state IDLE, idx=0, pending_o=0, addr_err_o=0, coeff_o=0, stream_o=0.
REQ-032 Reset loads both banks with the identity kernel: tap (N_COEFF-1)/2 = 1, all other taps = 0.
REQ-033 Reset mid-STREAM discards the remaining taps; streaming restarts only after vs_i has been sampled low and then high again.

Configuration
REQ-034 Macro CONV_CTRL_READBACK_EN defined: adds ports rd_addr_i (input, 4 bits) and rd_data_o (output, COEFF_W bits); rd_data_o is a register that holds, 1 cycle after the address, active[rd_addr_i], or 0 when rd_addr_i is out of range.
REQ-035 Macro CONV_CTRL_READBACK_EN undefined: the rd_addr_i and rd_data_o ports are absent and all other behaviour is unchanged.

Verification
REQ-036 Reset, hold vs_i low 4 cycles, then high 12 cycles -> coeff_o = 0,0,0,0,1,0,0,0,0 over the 9 stream cycles, then 0; stream_o high for exactly those 9 cycles.
REQ-037 Write taps 0..8 = 1..9, commit during IDLE -> pending_o for 1 cycle; next frame streams 1..9.
REQ-038 Commit while in HOLD -> wr_ready_o=0 and the active bank is unchanged until vs_i falls; swap on the first IDLE cycle; the following frame streams the new values.
REQ-039 Write with wr_addr_i=9 -> addr_err_o=1 and stays 1; the banks are unchanged; a later valid write still succeeds.
REQ-040 vs_i falls after 4 stream cycles -> IDLE; the next vs_i rise restarts at tap 0. Assert rst_n=0 mid-stream -> all outputs match REQ-031.
REQ-041 With CONV_CTRL_READBACK_EN: after the swap in REQ-037, rd_addr_i=3 -> rd_data_o=4 one cycle later; rd_addr_i=12 -> rd_data_o=0.

Source files
------------

// File: rtl/conv_coeff_ctrl_if.sv
// Host write/commit bus of conv_coeff_ctrl: shadow-bank writes, commit strobe and status.
interface conv_coeff_ctrl_if #(
  parameter int COEFF_W = 9
);
  logic               wr_valid_i;
  logic               wr_ready_o;
  logic [3:0]         wr_addr_i;
  logic [COEFF_W-1:0] wr_data_i;
  logic               commit_i;
  logic               pending_o;
  logic               addr_err_o;

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, commit_i,
    input  wr_ready_o, pending_o, addr_err_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, commit_i,
    output wr_ready_o, pending_o, addr_err_o
  );
endinterface

// File: rtl/conv_coeff_ctrl.sv
// Double-banked 3x3 coefficient store streaming taps to a convolution datapath on each vs_i frame.
// Optional readback port of the active bank: define CONV_CTRL_READBACK_EN.
//
// state  | meaning
// IDLE   | vs_i low (or not yet re-armed); tap 0 preloaded on coeff_o; bank swap allowed
// STREAM | taps 1..N_COEFF-1 driven, idx is the tap currently on coeff_o
// HOLD   | all taps sent, coeff_o = 0 until vs_i falls
module conv_coeff_ctrl #(
  parameter int COEFF_W = 9,
  parameter int N_COEFF = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vs_i,
  conv_coeff_ctrl_if.slave   wr_bus,
  output logic [COEFF_W-1:0] coeff_o,
  output logic               stream_o
`ifdef CONV_CTRL_READBACK_EN
  ,
  input  logic [3:0]         rd_addr_i,
  output logic [COEFF_W-1:0] rd_data_o
`endif
);

  localparam int IDX_W = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;
  localparam int MID   = (N_COEFF - 1) / 2;

  typedef enum logic [1:0] {IDLE, STREAM, HOLD} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_inc;
  logic [COEFF_W-1:0] shadow_q [N_COEFF];
  logic [COEFF_W-1:0] active_q [N_COEFF];
  logic [COEFF_W-1:0] active_d [N_COEFF];
  logic [COEFF_W-1:0] coeff_q;
  logic               pending_q;
  logic               addr_err_q;
  logic               vs_low_q;
  logic               wr_fire;
  logic               wr_in_range;
  logic               launch;
  logic               swap;

  assign wr_fire     = wr_bus.wr_valid_i & ~pending_q;
  assign wr_in_range = {1'b0, wr_bus.wr_addr_i} < 5'(N_COEFF);

  // A frame starts only on a sampled low-to-high of vs_i, so reset mid-frame waits for the next frame.
  assign launch = (state_q == IDLE) & vs_i & vs_low_q;
  // No swap in the launch cycle: that frame already committed to the old tap 0.
  assign swap   = pending_q & (state_q == IDLE) & ~launch;
  assign idx_inc = idx_q + IDX_W'(1);

  always_comb begin
    for (int i = 0; i < N_COEFF; i++) begin
      active_d[i] = swap ? shadow_q[i] : active_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      coeff_q    <= '0;
      pending_q  <= 1'b0;
      addr_err_q <= 1'b0;
      vs_low_q   <= 1'b0;
      for (int i = 0; i < N_COEFF; i++) begin
        shadow_q[i] <= (i == MID) ? COEFF_W'(1) : '0;
        active_q[i] <= (i == MID) ? COEFF_W'(1) : '0;
      end
    end else begin
      vs_low_q <= ~vs_i;

      if (wr_fire) begin
        if (wr_in_range) shadow_q[wr_bus.wr_addr_i] <= wr_bus.wr_data_i;
        else             addr_err_q <= 1'b1;
      end

      if (swap)                            pending_q <= 1'b0;
      else if (wr_bus.commit_i && !pending_q) pending_q <= 1'b1;

      for (int i = 0; i < N_COEFF; i++) begin
        active_q[i] <= active_d[i];
      end

      case (state_q)
        IDLE: begin
          idx_q <= '0;
          if (launch) begin
            state_q <= STREAM;
            idx_q   <= IDX_W'(1);
            coeff_q <= active_q[1];
          end else begin
            coeff_q <= active_d[0];
          end
        end
        STREAM: begin
          if (!vs_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            coeff_q <= active_q[0];
          end else if (idx_q == IDX_W'(N_COEFF - 1)) begin
            state_q <= HOLD;
            idx_q   <= '0;
            coeff_q <= '0;
          end else begin
            idx_q   <= idx_inc;
            coeff_q <= active_q[idx_inc];
          end
        end
        HOLD: begin
          idx_q <= '0;
          if (!vs_i) begin
            state_q <= IDLE;
            coeff_q <= active_q[0];
          end else begin
            coeff_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
          coeff_q <= '0;
        end
      endcase
    end
  end

  assign coeff_o           = coeff_q;
  assign stream_o          = (state_q == STREAM) | launch;
  assign wr_bus.wr_ready_o = ~pending_q;
  assign wr_bus.pending_o  = pending_q;
  assign wr_bus.addr_err_o = addr_err_q;

`ifdef CONV_CTRL_READBACK_EN
  logic [COEFF_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if ({1'b0, rd_addr_i} < 5'(N_COEFF)) begin
      rd_data_q <= active_q[rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;
`endif

endmodule
